spi_temp_reader: RTL and testbench

- Downstream consumer of the periodic toggle timer: every edge of the timer's square wave starts one read of the SPI temperature sensor.
- Read-only SPI master, mode 0 (CPOL=0, CPHA=0): asserts CS, clocks DATA_BITS bits MSB-first from the sensor, then presents the raw word with a one-cycle valid strobe.
- The captured word feeds downstream conversion/display logic.

---
 rtl/spi_temp_reader_pkg.sv | 14 +
 rtl/spi_temp_reader_if.sv | 23 ++
 rtl/spi_temp_reader_clk_gen.sv | 26 ++
 rtl/spi_temp_reader.sv | 99 +++++++++
 tb/tb_spi_temp_reader.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_temp_reader_pkg.sv
// Shared types and elaboration helpers for the SPI temperature reader.
package spi_temp_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    function automatic int unsigned div_width(input int unsigned clk_div);
        return $clog2(clk_div + 1);
    endfunction

    function automatic bit params_legal(input int unsigned clk_div, input int unsigned data_bits);
        return (clk_div >= 1) && (data_bits >= 2) && (data_bits <= 32);
    endfunction

endpackage

// File: rtl/spi_temp_reader_if.sv
// Trigger, SPI pins and result signals of the SPI temperature reader.
interface spi_temp_reader_if #(
    parameter int unsigned DATA_BITS = 16
);
    logic                 trig_in;
    logic                 miso_in;
    logic                 sclk_out;
    logic                 cs_n_out;
    logic [DATA_BITS-1:0] data_out;
    logic                 valid_out;
    logic                 busy_out;
    logic                 overrun_out;

    modport master (
        input  trig_in, miso_in,
        output sclk_out, cs_n_out, data_out, valid_out, busy_out, overrun_out
    );

    modport slave (
        output trig_in, miso_in,
        input  sclk_out, cs_n_out, data_out, valid_out, busy_out, overrun_out
    );
endinterface

// File: rtl/spi_temp_reader_clk_gen.sv
// Half-period tick generator: one tick every CLK_DIV enabled cycles.
module spi_clk_gen
    import spi_temp_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic en,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CW = div_width(CLK_DIV);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CW'(CLK_DIV - 1)) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_temp_reader.sv
// Read-only SPI mode-0 master: each trigger edge reads one DATA_BITS word MSB-first.
module spi_temp_reader
    import spi_temp_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 50,
    parameter int unsigned DATA_BITS = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    spi_temp_reader_if.master  bus
);
    localparam int unsigned BCW = $clog2(DATA_BITS + 1);

    if (!params_legal(CLK_DIV, DATA_BITS)) begin : g_bad_params
        $error("spi_temp_reader: CLK_DIV must be >= 1 and DATA_BITS in 2..32");
    end

    state_t               state, state_nx;
    logic                 trig_q, trig_edge;
    logic                 tick;
    logic                 ph, ph_nx;
    logic [BCW-1:0]       bit_cnt, bit_cnt_nx;
    logic [DATA_BITS-1:0] shift_q;

    assign trig_edge = bus.trig_in ^ trig_q;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en     (state != IDLE),
        .clear  (state == IDLE),
        .tick   (tick)
    );

    // ph is the sclk level within a bit period; a bit completes on the high-phase tick
    always_comb begin
        state_nx   = state;
        ph_nx      = ph;
        bit_cnt_nx = bit_cnt;
        case (state)
            IDLE: begin
                if (trig_edge) begin
                    state_nx   = SETUP;
                    ph_nx      = 1'b0;
                    bit_cnt_nx = '0;
                end
            end
            SETUP: if (tick) state_nx = SHIFT;
            SHIFT: begin
                if (tick) begin
                    ph_nx = !ph;
                    if (ph) begin
                        if (bit_cnt == BCW'(DATA_BITS - 1)) begin
                            state_nx   = HOLD;
                            bit_cnt_nx = '0;
                        end else begin
                            bit_cnt_nx = bit_cnt + 1'b1;
                        end
                    end
                end
            end
            HOLD: if (tick) state_nx = GAP;
            GAP:  if (tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state register
    always_ff @(posedge clk_in) begin
        trig_q <= bus.trig_in;
        if (rst_in) begin
            state           <= IDLE;
            ph              <= 1'b0;
            bit_cnt         <= '0;
            shift_q         <= '0;
            bus.sclk_out    <= 1'b0;
            bus.cs_n_out    <= 1'b1;
            bus.data_out    <= '0;
            bus.valid_out   <= 1'b0;
            bus.busy_out    <= 1'b0;
            bus.overrun_out <= 1'b0;
        end else begin
            state   <= state_nx;
            ph      <= ph_nx;
            bit_cnt <= bit_cnt_nx;
            if (state == SHIFT && tick && !ph) begin
                shift_q <= {shift_q[DATA_BITS-2:0], bus.miso_in};
            end
            bus.sclk_out    <= (state_nx == SHIFT) && ph_nx;
            bus.cs_n_out    <= !(state_nx inside {SETUP, SHIFT, HOLD});
            bus.busy_out    <= (state_nx != IDLE);
            bus.valid_out   <= (state == HOLD) && tick;
            bus.overrun_out <= trig_edge && (state != IDLE);
            if (state == HOLD && tick) begin
                bus.data_out <= shift_q;
            end
        end
    end
endmodule

// File: tb/tb_spi_temp_reader.sv
// Self-checking bench: behavioural SPI sensor models drive two reader configurations.
module tb_spi_temp_reader;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    spi_temp_reader_if #(.DATA_BITS(16)) a_if ();
    spi_temp_reader_if #(.DATA_BITS(8))  b_if ();

    spi_temp_reader #(.CLK_DIV(2), .DATA_BITS(16)) dut_a (
        .clk_in (clk),
        .rst_in (rst_a),
        .bus    (a_if.master)
    );

    spi_temp_reader #(.CLK_DIV(1), .DATA_BITS(8)) dut_b (
        .clk_in (clk),
        .rst_in (rst_b),
        .bus    (b_if.master)
    );

    // Sensor model: word chosen per transaction, MSB presented at CS fall, next bit after each SCLK fall
    logic [15:0] a_tab [0:63];
    logic [7:0]  b_tab [0:63];
    logic [15:0] a_cur = '0;
    logic [7:0]  b_cur = '0;
    int unsigned a_idx = 0, b_idx = 0;
    int unsigned a_starts = 0, a_rises = 0, a_csn_low = 0, a_gap = 0, a_valids = 0, a_ovr = 0;
    int unsigned b_starts = 0, b_rises = 0, b_csn_low = 0, b_sclk_hi = 0, b_valids = 0;
    logic a_prev_cs = 1'b1, a_prev_sclk = 1'b0;
    logic b_prev_cs = 1'b1, b_prev_sclk = 1'b0;

    always @(negedge clk) begin
        logic [15:0] w;
        int unsigned k;
        w = a_cur;
        k = a_idx;
        if (a_prev_cs && !a_if.cs_n_out) begin
            w = a_tab[a_starts[5:0]];
            k = 0;
            a_starts <= a_starts + 1;
        end else if (a_prev_sclk && !a_if.sclk_out && !a_if.cs_n_out) begin
            k = k + 1;
        end
        a_cur <= w;
        a_idx <= k;
        a_if.miso_in <= (k < 16) ? w[15 - k] : 1'b0;
        if (!a_prev_sclk && a_if.sclk_out) a_rises <= a_rises + 1;
        if (!a_if.cs_n_out) a_csn_low <= a_csn_low + 1;
        if (a_if.cs_n_out && a_if.busy_out) a_gap <= a_gap + 1;
        if (a_if.valid_out) a_valids <= a_valids + 1;
        if (a_if.overrun_out) a_ovr <= a_ovr + 1;
        a_prev_cs <= a_if.cs_n_out;
        a_prev_sclk <= a_if.sclk_out;
    end

    always @(negedge clk) begin
        logic [7:0] w;
        int unsigned k;
        w = b_cur;
        k = b_idx;
        if (b_prev_cs && !b_if.cs_n_out) begin
            w = b_tab[b_starts[5:0]];
            k = 0;
            b_starts <= b_starts + 1;
        end else if (b_prev_sclk && !b_if.sclk_out && !b_if.cs_n_out) begin
            k = k + 1;
        end
        b_cur <= w;
        b_idx <= k;
        b_if.miso_in <= (k < 8) ? w[7 - k] : 1'b0;
        if (!b_prev_sclk && b_if.sclk_out) b_rises <= b_rises + 1;
        if (b_if.sclk_out) b_sclk_hi <= b_sclk_hi + 1;
        if (!b_if.cs_n_out) b_csn_low <= b_csn_low + 1;
        if (b_if.valid_out) b_valids <= b_valids + 1;
        b_prev_cs <= b_if.cs_n_out;
        b_prev_sclk <= b_if.sclk_out;
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        tick(3);
        rst_a = 1'b0;
        tick(2);
    endtask

    task automatic wait_a_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (!a_if.busy_out) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_b_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (!b_if.busy_out) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        a_if.trig_in = 1'b0;
        b_if.trig_in = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick(4);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick(1);
        n_checks++;
        if ({a_if.sclk_out, a_if.cs_n_out, a_if.valid_out, a_if.busy_out, a_if.overrun_out} !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_a_ctrl: got %b expected 01000", {a_if.sclk_out, a_if.cs_n_out, a_if.valid_out, a_if.busy_out, a_if.overrun_out});
        end
        n_checks++;
        if (a_if.data_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_a_data: got %h expected 0000", a_if.data_out);
        end
        n_checks++;
        if ({b_if.sclk_out, b_if.cs_n_out, b_if.valid_out, b_if.busy_out, b_if.overrun_out, b_if.data_out} !== {5'b01000, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_b: got %b/%h expected 01000/00", {b_if.sclk_out, b_if.cs_n_out, b_if.valid_out, b_if.busy_out, b_if.overrun_out}, b_if.data_out);
        end
    endtask

    task automatic test_basic_read();
        logic [15:0] words [4];
        bit ok;
        int unsigned r0, c0, g0, v0, o0;
        words[0] = 16'hA5C3;
        for (int i = 1; i < 4; i++) words[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) begin
            a_tab[(a_starts + 0) % 64] = words[i];
            r0 = a_rises; c0 = a_csn_low; g0 = a_gap; v0 = a_valids; o0 = a_ovr;
            a_if.trig_in = ~a_if.trig_in;
            tick(1);
            n_checks++;
            if ({a_if.cs_n_out, a_if.busy_out} !== 2'b01) begin
                n_fail++;
                $display("FAIL basic_latency[%0d]: cs_n,busy got %b expected 01", i, {a_if.cs_n_out, a_if.busy_out});
            end
            wait_a_idle(ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL basic_timeout[%0d]: busy still %b expected 0", i, a_if.busy_out);
            end
            n_checks++;
            if (a_rises - r0 != 16) begin
                n_fail++;
                $display("FAIL basic_sclk_rises[%0d]: got %0d expected 16", i, a_rises - r0);
            end
            n_checks++;
            if (a_csn_low - c0 != 2 * (2 * 16 + 2)) begin
                n_fail++;
                $display("FAIL basic_cs_low[%0d]: got %0d expected 68", i, a_csn_low - c0);
            end
            n_checks++;
            if (a_gap - g0 != 2) begin
                n_fail++;
                $display("FAIL basic_gap[%0d]: got %0d expected 2", i, a_gap - g0);
            end
            n_checks++;
            if (a_valids - v0 != 1 || a_ovr != o0) begin
                n_fail++;
                $display("FAIL basic_strobes[%0d]: valid %0d overrun %0d expected 1 and 0", i, a_valids - v0, a_ovr - o0);
            end
            n_checks++;
            if (a_if.data_out !== words[i]) begin
                n_fail++;
                $display("FAIL basic_data[%0d]: got %h expected %h", i, a_if.data_out, words[i]);
            end
            tick($urandom_range(3, 30));
        end
    endtask

    task automatic test_both_polarities();
        bit ok;
        int unsigned s0, v0;
        a_if.trig_in = 1'b0;
        reset_a();
        s0 = a_starts; v0 = a_valids;
        a_tab[s0 % 64] = 16'h0123;
        a_tab[(s0 + 1) % 64] = 16'hFEDC;
        a_if.trig_in = 1'b1;
        tick(200);
        n_checks++;
        if (a_if.data_out !== 16'h0123) begin
            n_fail++;
            $display("FAIL polarity_rise_data: got %h expected 0123", a_if.data_out);
        end
        a_if.trig_in = 1'b0;
        tick(1);
        wait_a_idle(ok);
        n_checks++;
        if (!ok || a_starts - s0 != 2 || a_valids - v0 != 2) begin
            n_fail++;
            $display("FAIL polarity_count: idle %0d starts %0d valids %0d expected 1 2 2", ok, a_starts - s0, a_valids - v0);
        end
        n_checks++;
        if (a_if.data_out !== 16'hFEDC) begin
            n_fail++;
            $display("FAIL polarity_fall_data: got %h expected FEDC", a_if.data_out);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        int unsigned s0, v0, o0;
        logic [15:0] w1;
        reset_a();
        w1 = 16'($urandom);
        s0 = a_starts; v0 = a_valids; o0 = a_ovr;
        a_tab[s0 % 64] = w1;
        a_tab[(s0 + 1) % 64] = ~w1;
        a_if.trig_in = ~a_if.trig_in;
        tick(20);
        a_if.trig_in = ~a_if.trig_in;
        tick(1);
        wait_a_idle(ok);
        tick(100);
        n_checks++;
        if (!ok || a_ovr - o0 != 1) begin
            n_fail++;
            $display("FAIL overrun_pulse: idle %0d pulse cycles %0d expected 1 1", ok, a_ovr - o0);
        end
        n_checks++;
        if (a_starts - s0 != 1 || a_valids - v0 != 1) begin
            n_fail++;
            $display("FAIL overrun_single_txn: starts %0d valids %0d expected 1 1", a_starts - s0, a_valids - v0);
        end
        n_checks++;
        if (a_if.data_out !== w1) begin
            n_fail++;
            $display("FAIL overrun_data: got %h expected %h", a_if.data_out, w1);
        end
    endtask

    task automatic test_reset_mid_read();
        int unsigned r0, s0, v0;
        bit hit;
        reset_a();
        a_tab[a_starts % 64] = 16'($urandom) | 16'h8001;
        r0 = a_rises; s0 = a_starts; v0 = a_valids;
        a_if.trig_in = ~a_if.trig_in;
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick(1);
            if (a_rises - r0 == 7) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL midreset_reach_bit7: rises %0d expected 7", a_rises - r0);
        end
        rst_a = 1'b1;
        tick(1);
        n_checks++;
        if ({a_if.sclk_out, a_if.cs_n_out, a_if.busy_out, a_if.valid_out} !== 4'b0100 || a_if.data_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL midreset_outputs: sclk,cs_n,busy,valid %b data %h expected 0100 0000",
                     {a_if.sclk_out, a_if.cs_n_out, a_if.busy_out, a_if.valid_out}, a_if.data_out);
        end
        rst_a = 1'b0;
        tick(150);
        n_checks++;
        if (a_valids != v0 || a_starts - s0 != 1 || a_if.data_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL midreset_aftermath: valids %0d starts %0d data %h expected 0 1 0000", a_valids - v0, a_starts - s0, a_if.data_out);
        end
    endtask

    task automatic test_trig_high_at_reset();
        int unsigned s0;
        rst_a = 1'b1;
        tick(1);
        a_if.trig_in = 1'b1;
        tick(3);
        s0 = a_starts;
        rst_a = 1'b0;
        tick(100);
        n_checks++;
        if (a_starts != s0 || a_if.busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL trig_high_reset: starts %0d busy %b expected 0 0", a_starts - s0, a_if.busy_out);
        end
    endtask

    task automatic test_min_divider();
        logic [7:0] w;
        bit ok;
        int unsigned r0, c0, h0, v0;
        b_if.trig_in = 1'b0;
        rst_b = 1'b1;
        tick(3);
        rst_b = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            w = (i == 0) ? 8'h81 : 8'($urandom);
            b_tab[b_starts % 64] = w;
            r0 = b_rises; c0 = b_csn_low; h0 = b_sclk_hi; v0 = b_valids;
            b_if.trig_in = ~b_if.trig_in;
            wait_b_idle(ok);
            n_checks++;
            if (!ok || b_csn_low - c0 != 18) begin
                n_fail++;
                $display("FAIL mindiv_cs_low[%0d]: idle %0d cycles %0d expected 1 18", i, ok, b_csn_low - c0);
            end
            n_checks++;
            if (b_rises - r0 != 8 || b_sclk_hi - h0 != 8) begin
                n_fail++;
                $display("FAIL mindiv_sclk[%0d]: rises %0d high cycles %0d expected 8 8", i, b_rises - r0, b_sclk_hi - h0);
            end
            n_checks++;
            if (b_if.data_out !== w || b_valids - v0 != 1) begin
                n_fail++;
                $display("FAIL mindiv_data[%0d]: got %h valids %0d expected %h 1", i, b_if.data_out, b_valids - v0, w);
            end
            tick($urandom_range(2, 10));
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int unsigned s0, v0, o0;
        logic [15:0] w1, w2;
        reset_a();
        w1 = 16'($urandom);
        w2 = 16'($urandom);
        s0 = a_starts; v0 = a_valids; o0 = a_ovr;
        a_tab[s0 % 64] = w1;
        a_tab[(s0 + 1) % 64] = w2;
        a_if.trig_in = ~a_if.trig_in;
        wait_a_idle(ok);
        a_if.trig_in = ~a_if.trig_in;
        tick(1);
        n_checks++;
        if (!ok || {a_if.cs_n_out, a_if.busy_out} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_accept: idle %0d cs_n,busy %b expected 1 01", ok, {a_if.cs_n_out, a_if.busy_out});
        end
        wait_a_idle(ok);
        n_checks++;
        if (!ok || a_ovr != o0 || a_valids - v0 != 2 || a_starts - s0 != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: idle %0d overrun %0d valids %0d starts %0d expected 1 0 2 2",
                     ok, a_ovr - o0, a_valids - v0, a_starts - s0);
        end
        n_checks++;
        if (a_if.data_out !== w2) begin
            n_fail++;
            $display("FAIL b2b_data: got %h expected %h", a_if.data_out, w2);
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_both_polarities();
        test_overrun();
        test_reset_mid_read();
        test_trig_high_at_reset();
        test_min_divider();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
